// File: rtl/wb_shared_bus.sv
// Pipelined Wishbone shared bus: round-robin master arbitration, base/mask slave decode,
// in-flight request tracking and an internal error responder for unmapped addresses.
module wb_shared_bus #(
    parameter int unsigned                        NumMasters     = 2,
    parameter int unsigned                        NumSlaves      = 2,
    parameter int unsigned                        AddrWidth      = 30,
    parameter logic [NumSlaves*AddrWidth-1:0]     SlaveBase      = '0,
    parameter logic [NumSlaves*AddrWidth-1:0]     SlaveMask      = '0,
    parameter int unsigned                        MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NumMasters-1:0]           m_cyc_i,
    input  logic [NumMasters-1:0]           m_stb_i,
    input  logic [NumMasters-1:0]           m_we_i,
    input  logic [NumMasters*AddrWidth-1:0] m_addr_i,
    input  logic [NumMasters*4-1:0]         m_sel_i,
    input  logic [NumMasters*32-1:0]        m_data_i,
    output logic [NumMasters*32-1:0]        m_data_o,
    output logic [NumMasters-1:0]           m_ack_o,
    output logic [NumMasters-1:0]           m_err_o,
    output logic [NumMasters-1:0]           m_stall_o,
    output logic [NumSlaves-1:0]            s_cyc_o,
    output logic [NumSlaves-1:0]            s_stb_o,
    output logic [NumSlaves-1:0]            s_we_o,
    output logic [AddrWidth-1:0]            s_addr_o,
    output logic [3:0]                      s_sel_o,
    output logic [31:0]                     s_data_o,
    input  logic [NumSlaves*32-1:0]         s_data_i,
    input  logic [NumSlaves-1:0]            s_ack_i,
    input  logic [NumSlaves-1:0]            s_err_i,
    input  logic [NumSlaves-1:0]            s_stall_i
);
    localparam int unsigned MIdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int unsigned SIdxW = $clog2(NumSlaves + 1);
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam logic [SIdxW-1:0] ErrIdx = SIdxW'(NumSlaves);
    localparam logic [CntW-1:0]  CntMax = CntW'(MaxOutstanding);

    typedef enum logic {ST_IDLE, ST_GRANTED} state_e;

    state_e            state_q, state_d;
    logic [MIdxW-1:0]  grant_idx_q, grant_idx_d;
    logic [MIdxW-1:0]  last_idx_q, last_idx_d;
    logic [CntW-1:0]   outstanding_q, outstanding_d;
    logic [SIdxW-1:0]  lock_idx_q, lock_idx_d;
    logic              err_pend_q, err_pend_d;

    logic                 granted;
    logic                 req_cyc, req_stb, req_we;
    logic [AddrWidth-1:0] req_addr;
    logic [3:0]           req_sel;
    logic [31:0]          req_data;
    logic [SIdxW-1:0]     target;
    logic                 slv_stall, blocked, req_stall, accept;
    logic                 rsp_ack, rsp_err, rsp_live, rsp_take;
    logic [31:0]          rsp_data;

    always_comb begin
        granted  = (state_q == ST_GRANTED);
        req_cyc  = 1'b0;
        req_stb  = 1'b0;
        req_we   = 1'b0;
        req_addr = '0;
        req_sel  = '0;
        req_data = '0;
        for (int m = 0; m < NumMasters; m++) begin
            if (grant_idx_q == MIdxW'(m)) begin
                req_cyc  = m_cyc_i[m];
                req_stb  = m_stb_i[m];
                req_we   = m_we_i[m];
                req_addr = m_addr_i[m*AddrWidth +: AddrWidth];
                req_sel  = m_sel_i[m*4 +: 4];
                req_data = m_data_i[m*32 +: 32];
            end
        end

        // Descending scan so the lowest matching slave index overrides higher ones.
        target = ErrIdx;
        for (int s = NumSlaves - 1; s >= 0; s--) begin
            if ((req_addr & SlaveMask[s*AddrWidth +: AddrWidth]) == SlaveBase[s*AddrWidth +: AddrWidth])
                target = SIdxW'(s);
        end

        slv_stall = 1'b0;
        rsp_ack   = 1'b0;
        rsp_err   = err_pend_q;
        rsp_data  = '0;
        for (int s = 0; s < NumSlaves; s++) begin
            if (target == SIdxW'(s))
                slv_stall = s_stall_i[s];
            if (lock_idx_q == SIdxW'(s)) begin
                rsp_ack  = s_ack_i[s];
                rsp_err  = s_err_i[s] | err_pend_q;
                rsp_data = s_data_i[s*32 +: 32];
            end
        end

        // Responses are only tracked from one slave at a time, so a new target waits for a drain.
        blocked   = (outstanding_q == CntMax) || ((outstanding_q != '0) && (target != lock_idx_q));
        req_stall = blocked || slv_stall;
        accept    = granted && req_cyc && req_stb && !req_stall;
        rsp_live  = granted && (outstanding_q != '0);
        rsp_take  = rsp_live && (rsp_ack || rsp_err);
    end

    always_comb begin
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_data_o  = '0;
        s_cyc_o   = '0;
        s_stb_o   = '0;
        s_we_o    = '0;
        s_addr_o  = '0;
        s_sel_o   = '0;
        s_data_o  = '0;
        if (granted) begin
            for (int m = 0; m < NumMasters; m++) begin
                if (grant_idx_q == MIdxW'(m)) begin
                    m_stall_o[m]         = req_stall;
                    m_ack_o[m]           = rsp_live && rsp_ack;
                    m_err_o[m]           = rsp_live && rsp_err;
                    m_data_o[m*32 +: 32] = rsp_data;
                end
            end
            s_cyc_o  = '1;
            s_we_o   = {NumSlaves{req_we}};
            s_addr_o = req_addr;
            s_sel_o  = req_sel;
            s_data_o = req_data;
            for (int s = 0; s < NumSlaves; s++) begin
                if (target == SIdxW'(s))
                    s_stb_o[s] = req_cyc && req_stb && !blocked;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        last_idx_d    = last_idx_q;
        outstanding_d = outstanding_q;
        lock_idx_d    = lock_idx_q;
        err_pend_d    = err_pend_q;
        case (state_q)
            ST_IDLE: begin
                // Round-robin: search starts just after the previous winner.
                for (int i = NumMasters; i >= 1; i--) begin
                    int cand;
                    cand = (int'(last_idx_q) + i) % NumMasters;
                    if (m_cyc_i[cand]) begin
                        state_d     = ST_GRANTED;
                        grant_idx_d = MIdxW'(cand);
                        last_idx_d  = MIdxW'(cand);
                    end
                end
            end
            default: begin
                if (!req_cyc) begin
                    state_d       = ST_IDLE;
                    outstanding_d = '0;
                    err_pend_d    = 1'b0;
                end else begin
                    if (accept)
                        lock_idx_d = target;
                    outstanding_d = outstanding_q + CntW'(accept) - CntW'(rsp_take);
                    err_pend_d    = accept && (target == ErrIdx);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            grant_idx_q   <= '0;
            last_idx_q    <= MIdxW'(NumMasters - 1);
            outstanding_q <= '0;
            lock_idx_q    <= ErrIdx;
            err_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            last_idx_q    <= last_idx_d;
            outstanding_q <= outstanding_d;
            lock_idx_q    <= lock_idx_d;
            err_pend_q    <= err_pend_d;
        end
    end
endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus: two masters, two slaves with configurable response delay,
// expected responses queued at acceptance and matched (master, kind, data, cycle) on return.
module tb_wb_shared_bus;
    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 30;
    localparam int MO = 4;
    localparam logic [NS*AW-1:0] BASE = {30'h1000000, 30'h0000000};
    localparam logic [NS*AW-1:0] MASK = {30'h3000000, 30'h3000000};

    logic              clk;
    logic              reset_i;
    logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [NM*AW-1:0]  m_addr_i;
    logic [NM*4-1:0]   m_sel_i;
    logic [NM*32-1:0]  m_data_i;
    logic [NM*32-1:0]  m_data_o;
    logic [NM-1:0]     m_ack_o, m_err_o, m_stall_o;
    logic [NS-1:0]     s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_addr_o;
    logic [3:0]        s_sel_o;
    logic [31:0]       s_data_o;
    logic [NS*32-1:0]  s_data_i;
    logic [NS-1:0]     s_ack_i, s_err_i, s_stall_i;

    wb_shared_bus #(
        .NumMasters(NM), .NumSlaves(NS), .AddrWidth(AW),
        .SlaveBase(BASE), .SlaveMask(MASK), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_addr_i(m_addr_i), .m_sel_i(m_sel_i), .m_data_i(m_data_i),
        .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_sel_o(s_sel_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i)
    );

    typedef struct packed {
        int          m;
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } srsp_t;

    exp_t  exp_q[$];
    srsp_t sq0[$];
    srsp_t sq1[$];
    int    slv_delay[2];
    int    cyc_cnt  = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slv_data(input int s, input logic [29:0] a);
        if (a == 30'h1000004)
            return 32'hDEADBEEF;
        return {s[1:0], a};
    endfunction

    function automatic int model_decode(input logic [29:0] a);
        if ((a & 30'h3000000) == 30'h0000000) return 0;
        if ((a & 30'h3000000) == 30'h1000000) return 1;
        return -1;
    endfunction

    // Slave models: take a request when strobed and not stalled, answer slv_delay cycles later.
    initial begin
        s_ack_i  = '0;
        s_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            s_ack_i  = '0;
            s_data_i = '0;
            if (sq0.size() > 0 && sq0[0].due <= cyc_cnt) begin
                s_ack_i[0]      = 1'b1;
                s_data_i[31:0]  = sq0[0].data;
                sq0.delete(0);
            end
            if (sq1.size() > 0 && sq1[0].due <= cyc_cnt) begin
                s_ack_i[1]      = 1'b1;
                s_data_i[63:32] = sq1[0].data;
                sq1.delete(0);
            end
        end
    end

    always @(negedge clk) begin
        srsp_t r;
        if (s_cyc_o[0] && s_stb_o[0] && !s_stall_i[0]) begin
            r.due  = cyc_cnt + slv_delay[0];
            r.data = slv_data(0, s_addr_o);
            sq0.push_back(r);
        end
        if (s_cyc_o[1] && s_stb_o[1] && !s_stall_i[1]) begin
            r.due  = cyc_cnt + slv_delay[1];
            r.data = slv_data(1, s_addr_o);
            sq1.push_back(r);
        end
    end

    // Scoreboard: match responses first, then record this cycle's acceptances.
    always @(negedge clk) begin
        exp_t e;
        int   s;
        logic [29:0] a;
        if (!reset_i) begin
            for (int m = 0; m < NM; m++) begin
                if (m_ack_o[m] || m_err_o[m]) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_rsp", {m_ack_o[m], m_err_o[m]}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rsp_master", m, e.m);
                        check_eq("rsp_err", m_err_o[m], e.err);
                        check_eq("rsp_ack", m_ack_o[m], !e.err);
                        check_eq("rsp_cycle", cyc_cnt, e.due);
                        if (!e.err)
                            check_eq("rsp_data", m_data_o[m*32 +: 32], e.data);
                    end
                end
            end
            for (int m = 0; m < NM; m++) begin
                if (m_cyc_i[m] && m_stb_i[m] && !m_stall_o[m]) begin
                    a     = m_addr_i[m*AW +: AW];
                    s     = model_decode(a);
                    e.m   = m;
                    e.err = (s < 0);
                    e.data = (s < 0) ? 32'h0 : slv_data(s, a);
                    e.due = cyc_cnt + ((s < 0) ? 1 : slv_delay[s]);
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int m, input logic [29:0] a, output int waited);
        m_stb_i[m]           = 1'b1;
        m_addr_i[m*AW +: AW] = a;
        waited = 0;
        @(negedge clk);
        while (m_stall_o[m] && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 40)
            check_eq("req_timeout", m_stall_o[m], 1'b0);
        tick();
    endtask

    initial begin
        int w;
        int wsum;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_addr_i = '0;
        m_sel_i = '1; m_data_i = '0; s_stall_i = '0; s_err_i = '0;
        slv_delay[0] = 1;
        slv_delay[1] = 1;
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", m_stall_o, 2'b11);
        check_eq("rst_s_cyc", s_cyc_o, 2'b00);
        check_eq("rst_s_stb", s_stb_o, 2'b00);
        check_eq("rst_ack_err", {m_ack_o, m_err_o}, 4'b0000);
        check_eq("rst_m_data", m_data_o, 64'h0);
        check_eq("rst_s_addr", s_addr_o, 30'h0);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        check_eq("idle_stall", m_stall_o, 2'b11);
        check_eq("idle_s_cyc", s_cyc_o, 2'b00);

        // Simultaneous request: master 0 wins after reset.
        tick();
        m_cyc_i = 2'b11;
        @(negedge clk);
        check_eq("arb_wait", m_stall_o, 2'b11);
        tick();
        m_stb_i[0]     = 1'b1;
        m_addr_i[29:0] = 30'h1000004;
        @(negedge clk);
        check_eq("grant_m0", m_stall_o, 2'b10);
        check_eq("decode_stb", s_stb_o, 2'b10);
        check_eq("grant_s_cyc", s_cyc_o, 2'b11);
        check_eq("grant_s_addr", s_addr_o, 30'h1000004);
        tick();
        m_stb_i[0] = 1'b0;
        @(negedge clk);
        check_eq("ack_same_cycle", m_ack_o, 2'b01);
        check_eq("read_data", m_data_o[31:0], 32'hDEADBEEF);
        check_eq("other_data_zero", m_data_o[63:32], 32'h0);
        tick();
        m_cyc_i[0] = 1'b0;
        tick();
        @(negedge clk);
        check_eq("arb_gap", m_stall_o, 2'b11);
        tick();
        @(negedge clk);
        check_eq("grant_m1", m_stall_o, 2'b01);

        // Unmapped accesses, then a slave-1 request that must wait for the error.
        tick();
        m_stb_i[1]      = 1'b1;
        m_addr_i[59:30] = 30'h2000000;
        @(negedge clk);
        check_eq("unmapped_no_stb", s_stb_o, 2'b00);
        check_eq("unmapped_accept", m_stall_o[1], 1'b0);
        tick();
        do_req(1, 30'h2000001, w);
        check_eq("unmapped_b2b_wait", w, 0);
        do_req(1, 30'h1000008, w);
        check_eq("err_drain_wait", w, 1);
        m_stb_i[1] = 1'b0;
        repeat (3) tick();

        // Slave stall passes through to the granted master.
        s_stall_i[0]    = 1'b1;
        m_stb_i[1]      = 1'b1;
        m_addr_i[59:30] = 30'h10;
        @(negedge clk);
        check_eq("slave_stall_pass", m_stall_o[1], 1'b1);
        tick();
        s_stall_i[0] = 1'b0;
        @(negedge clk);
        check_eq("slave_stall_release", m_stall_o[1], 1'b0);
        tick();
        m_stb_i[1] = 1'b0;
        repeat (3) tick();

        // Pipelined throughput up to the outstanding limit.
        slv_delay[0] = 6;
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1, 30'(32'h100 + i), w);
            wsum += w;
        end
        check_eq("b2b_no_stall", wsum, 0);
        do_req(1, 30'h104, w);
        check_eq("full_stalled", (w > 0), 1'b1);
        check_eq("full_released", (w >= 2 && w <= 3), 1'b1);
        m_stb_i[1] = 1'b0;
        repeat (10) tick();

        // Master abandons its cycle with two requests in flight.
        slv_delay[0] = 3;
        do_req(1, 30'h200, w);
        do_req(1, 30'h201, w);
        m_stb_i[1] = 1'b0;
        m_cyc_i[1] = 1'b0;
        check_eq("drop_inflight", exp_q.size(), 2);
        exp_q.delete();
        tick();
        @(negedge clk);
        check_eq("late_ack_dropped", m_ack_o, 2'b00);
        check_eq("drop_idle_stall", m_stall_o, 2'b11);
        tick();
        @(negedge clk);
        check_eq("late_ack_dropped2", m_ack_o, 2'b00);
        tick();
        m_cyc_i[0] = 1'b1;
        tick();
        do_req(0, 30'h1000010, w);
        check_eq("after_drop_free", w, 0);
        m_stb_i[0] = 1'b0;
        tick();

        // Reset while a response is still pending at the slave.
        slv_delay[1] = 3;
        do_req(0, 30'h1000020, w);
        reset_i    = 1'b1;
        m_stb_i[0] = 1'b0;
        m_cyc_i[0] = 1'b0;
        check_eq("rst_inflight", exp_q.size(), 1);
        exp_q.delete();
        tick();
        @(negedge clk);
        check_eq("rst_mid_stall", m_stall_o, 2'b11);
        check_eq("rst_mid_s_cyc", s_cyc_o, 2'b00);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        check_eq("rst_late_ack", m_ack_o, 2'b00);
        tick();
        m_cyc_i[0] = 1'b1;
        tick();
        do_req(0, 30'h30, w);
        check_eq("rst_clears_state", w, 0);
        m_stb_i[0] = 1'b0;
        repeat (8) tick();
        m_cyc_i = '0;
        tick();
        check_eq("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_shared_bus.md
# wb_shared_bus

Parametrised pipelined-Wishbone shared-bus interconnect: NumMasters bus masters to NumSlaves slaves over one arbitrated channel. It replaces the fixed point-to-point wiring between CPU instruction/data ports and ROM/RAM in the system top. It arbitrates masters round-robin and decodes addresses with base/mask pairs. It tracks in-flight pipelined requests and returns a bus error for unmapped addresses.

## Interface
- NumMasters, 2, number of master ports (≥1)
- NumSlaves, 2, number of slave ports (≥1)
- AddrWidth, 30, word-address width
- SlaveBase, '0, packed NumSlaves×AddrWidth; slave s base address
- SlaveMask, '0, packed NumSlaves×AddrWidth; slave s matches when (addr & mask) == base
- MaxOutstanding, 4, maximum accepted-but-unanswered requests (power of two, ≥1)
- clk_i  in  1  single clock; all state on rising edge
- reset_i  in  1  synchronous, active-high reset
- m_cyc_i, m_stb_i, m_we_i  in  NumMasters  per-master cycle, strobe and write enable
- m_addr_i  in  NumMasters×AddrWidth  per-master word address
- m_sel_i  in  NumMasters×4  byte selects
- m_data_i  in  NumMasters×32  write data
- m_data_o  out  NumMasters×32  read data (granted master's slot valid; others 0)
- m_ack_o, m_err_o, m_stall_o  out  NumMasters  per-master response and stall
- s_cyc_o, s_stb_o, s_we_o  out  NumSlaves  per-slave cycle, strobe and write enable
- s_addr_o  out  AddrWidth  shared address
- s_sel_o  out  4  shared byte selects
- s_data_o  out  32  shared write data
- s_data_i  in  NumSlaves×32  slave read data
- s_ack_i, s_err_i, s_stall_i  in  NumSlaves  slave response and stall

## Operation
- State: grant_valid, grant_idx, last_idx, outstanding count (0..MaxOutstanding), lock_idx (0..NumSlaves; NumSlaves = internal error responder), err_pend.
- Reset: grant_valid=0, last_idx=NumMasters-1, outstanding=0, err_pend=0.
- Arbitration states:
  - IDLE (grant_valid=0): if any m_cyc_i is high, grant the first requester searching last_idx+1, last_idx+2, … with wrap. Set grant_valid=1, grant_idx=last_idx=winner.
  - GRANTED: held while m_cyc_i[grant_idx]=1. When it drops, go to IDLE, clear outstanding and err_pend; no new grant in that same cycle.
- While granted:
  - s_cyc_o is all-ones.
  - s_addr/sel/data/we come from the granted master.
  - s_stb_o is one-hot on the decoded slave; the lowest matching index wins.
  - No match selects the error responder; no s_stb_o is asserted.
- Acceptance = m_stb & !m_stall on the granted master.
- m_stall_o[granted] = 1 if outstanding == MaxOutstanding, else 1 if outstanding > 0 and decoded target ≠ lock_idx, else s_stall_i[target] (0 for the error responder).
- On acceptance: lock_idx = target, outstanding += 1 (minus any simultaneous response). For the error responder, err_pend is set so that m_err_o pulses on the next cycle.
- Responses come only from lock_idx:
  - m_ack_o = s_ack_i[lock], m_err_o = s_err_i[lock] | err_pend.
  - m_data_o = s_data_i[lock].
  - Each response decrements outstanding. Responses with outstanding = 0 are dropped.
- Non-granted masters: m_stall_o=1, m_ack_o=0, m_err_o=0, m_data_o=0.
- Reset mid-transfer: all state is cleared on the next edge; late slave responses are ignored.

## Timing
- Outputs after reset: s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_err_o=0, m_stall_o all-ones, data/addr outputs 0.
- Arbitration latency: 1 cycle from m_cyc_i rising (bus idle) to grant; the first stb can be accepted in the grant cycle.
- Request path (master → slave) and response path (slave → master) are combinational once granted; zero added latency.
- Error responder: err is returned exactly 1 cycle after acceptance; back-to-back unmapped requests give one err per cycle.
- Simultaneous acceptance and response in one cycle: outstanding stays unchanged.
- Throughput: one request per cycle to one slave, up to MaxOutstanding in flight.
- Switching target slave costs a drain to outstanding = 0.

## Test plan
- Reset, then no requests → all m_stall_o=1, s_cyc_o=0, outstanding=0.
- Masters 0 and 1 both raise cyc in the same cycle after reset → master 0 granted. It drops cyc after one read; master 1 is granted 2 cycles later (release cycle + arbitration cycle).
- NumSlaves=2, base 0x0000000/0x1000000, mask 0x3000000; master reads addr 0x1000004 → s_stb_o=2'b10. Slave returns 0xDEADBEEF with ack → m_data_o=0xDEADBEEF and m_ack_o=1 on the same cycle.
- Five back-to-back stb to slave 0 with slave ack delayed 6 cycles, MaxOutstanding=4 → the 5th is stalled until the first ack, then accepted in that ack cycle.
- Read 0x2000000 (unmapped) → no s_stb_o; m_err_o=1 exactly one cycle after acceptance; a following request to slave 1 is stalled until err is returned.
- Master drops cyc with 2 outstanding → grant released, outstanding=0; a slave ack arriving 1 cycle later produces no m_ack_o.
